lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store controller between the execute stage and the byte-addressable data_memory.
//  Takes one RV32I load/store request per transaction over a valid/ready handshake.
//  Decodes funct3, checks alignment and address range, drives the memory port for one cycle,
//  zero-extends LBU/LHU, and returns a registered response with an error code.
// PARAMETERS
//  MEM_BYTES  128  size of data memory in bytes; an access is legal when addr+size-1 < MEM_BYTES
//  XLEN       32   data/address width
// PORTS
//  clk           in   1     system clock, rising edge
//  reset         in   1     asynchronous, active-high reset
//  req_valid     in   1     request present
//  req_ready     out  1     controller can accept; high only in IDLE
//  req_we        in   1     1=store, 0=load
//  req_funct3    in   3     RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr      in   XLEN  byte address (rs1+imm, already computed)
//  req_wdata     in   XLEN  store data (rs2)
//  rsp_valid     out  1     response present; held until rsp_ready
//  rsp_ready     in   1     consumer accepts response
//  rsp_rdata     out  XLEN  extended load data; 0 for stores and errors
//  rsp_err       out  2     00 OK, 01 MISALIGNED, 10 OUT_OF_RANGE, 11 ILLEGAL_FUNCT3
//  d_wr_en       out  1     memory write strobe
//  dAddr         out  XLEN  memory byte address
//  dWdata        out  XLEN  memory write data
//  store_size    out  2     00 byte, 01 half, 10 word
//  load_size     out  2     00 byte, 01 half, 10 word
//  dRdata        in   XLEN  memory read data (combinational, sign-extended for b/h)
// BEHAVIOUR
//  - FSM states: IDLE, ACCESS, RESP. Reset -> IDLE.
//  - Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=00, d_wr_en=0, dAddr=0,
//    dWdata=0, store_size=10, load_size=10. Reset mid-transaction aborts it; no write is issued.
//  - IDLE: when req_valid && req_ready, latch we/funct3/addr/wdata and classify the request.
//    Error priority: ILLEGAL (load f3 in {011,110,111}; store f3 > 010) > MISALIGNED
//    (half and addr[0]; word and addr[1:0]!=0) > OUT_OF_RANGE (addr+size-1 >= MEM_BYTES,
//    computed in XLEN+1 bits so wrap cannot pass).
//    Error -> RESP with rsp_err set and rdata=0; memory is not touched. OK -> ACCESS.
//  - ACCESS (exactly 1 cycle): dAddr/dWdata/store_size/load_size come from latched regs.
//    d_wr_en=1 only in ACCESS, and only for stores.
//    Loads: capture dRdata at the end of ACCESS. LB/LH/LW pass through.
//    LBU -> {24'b0, dRdata[7:0]}. LHU -> {16'b0, dRdata[15:0]}. Go to RESP.
//  - RESP: rsp_valid=1, outputs stable until rsp_ready. rsp_valid&&rsp_ready -> IDLE.
//    rsp_valid drops the next cycle.
//  - Latency: accept at edge N, write/read at edge N+1, rsp_valid visible from N+1 to N+2.
//    Best-case throughput: 1 request per 3 cycles. Errors skip ACCESS: rsp_valid one cycle sooner.
//  - req_valid during ACCESS/RESP is ignored (req_ready=0); the request must be held by upstream.
//  - d_wr_en is decoded from state, so it never glitches high outside ACCESS.
//  - Size codes to memory: b/bu=00, h/hu=01, w=10. Code 11 is never driven.
// STRUCTURE
//  - lsu_pkg: state_e enum, F3_LB..F3_SW localparams, SIZE_B/H/W, ERR_OK/MISAL/OOR/ILL codes.
//  - One sub-module, lsu_load_ext: combinational funct3 + dRdata -> extended rdata.
//  - Top keeps the FSM, request latch, error classifier and response registers.
// TESTING
//  1 SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> store OK, rdata=0xDEADBEEF, err=00.
//  2 SB 0x21 data 0x80; LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080.
//  3 LH 0x03 -> err=01, rdata=0; LW 0x7E -> err=01; no d_wr_en pulse on SW 0x06.
//  4 LW 0x7C -> OK; LW 0x80 -> err=10; SH 0x7F -> err=01 (misaligned outranks range);
//    SB 0xFFFFFFFF -> err=10 (no wrap).
//  5 load f3=011 -> err=11; store f3=100 -> err=11; memory unchanged
//    (check with readback, including a word initialised from 0x87654321).
//  6 Hold rsp_ready=0 for 5 cycles -> rsp stable, req_ready=0.
//    Assert reset during ACCESS of an SW -> d_wr_en drops at once, memory unchanged, IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store controller: FSM states,
// RV32I funct3 codes, memory size codes and response error codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_MISAL = 2'b01;
  localparam logic [1:0] ERR_OOR   = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  // Illegal funct3 codes are folded onto a legal size so code 11 never reaches memory.
  function automatic logic [1:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = SIZE_B;
      2'b01:   size_of = SIZE_H;
      default: size_of = SIZE_W;
    endcase
  endfunction

  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    if (we) funct3_illegal = (funct3 > F3_SW);
    else    funct3_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result extension: LBU/LHU are zero-extended, every other load passes the
// memory's (already sign-extended) read data through unchanged.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] rdata
);

  always_comb begin
    case (funct3)
      F3_LBU:  rdata = {{(XLEN-8){1'b0}}, mem_rdata[7:0]};
      F3_LHU:  rdata = {{(XLEN-16){1'b0}}, mem_rdata[15:0]};
      default: rdata = mem_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: accepts one request in IDLE, classifies it, drives the
// data memory for a single ACCESS cycle and holds a registered response in RESP.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 128,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [1:0]      rsp_err,
  output logic            d_wr_en,
  output logic [XLEN-1:0] dAddr,
  output logic [XLEN-1:0] dWdata,
  output logic [1:0]      store_size,
  output logic [1:0]      load_size,
  input  logic [XLEN-1:0] dRdata
);

  localparam logic [XLEN:0] MEM_LIMIT = (XLEN+1)'(MEM_BYTES);

  state_e          state_reg, state_next;
  logic            we_reg, we_next;
  logic [2:0]      funct3_reg, funct3_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic [XLEN-1:0] wdata_reg, wdata_next;
  logic [1:0]      size_reg, size_next;
  logic [XLEN-1:0] rdata_reg, rdata_next;
  logic [1:0]      err_reg, err_next;

  logic [1:0]      req_size;
  logic [1:0]      last_off;
  logic [XLEN:0]   last_byte;
  logic            req_ill;
  logic            req_misal;
  logic            req_oor;
  logic [1:0]      req_err;
  logic [XLEN-1:0] ext_rdata;

  // Request classifier; the extra top bit in last_byte keeps a wrapping address out of range.
  always_comb begin
    req_size = size_of(req_funct3);
    case (req_size)
      SIZE_B:  last_off = 2'd0;
      SIZE_H:  last_off = 2'd1;
      default: last_off = 2'd3;
    endcase
    last_byte = {1'b0, req_addr} + {{(XLEN-1){1'b0}}, last_off};
    req_ill   = funct3_illegal(req_we, req_funct3);
    req_misal = ((req_size == SIZE_H) && req_addr[0]) ||
                ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
    req_oor   = (last_byte >= MEM_LIMIT);
    if (req_ill)        req_err = ERR_ILL;
    else if (req_misal) req_err = ERR_MISAL;
    else if (req_oor)   req_err = ERR_OOR;
    else                req_err = ERR_OK;
  end

  lsu_load_ext #(
    .XLEN(XLEN)
  ) u_load_ext (
    .funct3   (funct3_reg),
    .mem_rdata(dRdata),
    .rdata    (ext_rdata)
  );

  always_comb begin
    state_next  = state_reg;
    we_next     = we_reg;
    funct3_next = funct3_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    size_next   = size_reg;
    rdata_next  = rdata_reg;
    err_next    = err_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          we_next     = req_we;
          funct3_next = req_funct3;
          addr_next   = req_addr;
          wdata_next  = req_wdata;
          size_next   = req_size;
          rdata_next  = '0;
          err_next    = req_err;
          state_next  = (req_err == ERR_OK) ? S_ACCESS : S_RESP;
        end
      end
      S_ACCESS: begin
        rdata_next = we_reg ? '0 : ext_rdata;
        state_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      size_reg   <= SIZE_W;
      rdata_reg  <= '0;
      err_reg    <= ERR_OK;
    end else begin
      state_reg  <= state_next;
      we_reg     <= we_next;
      funct3_reg <= funct3_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      size_reg   <= size_next;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
    end
  end

  // Strobes decode straight from state so a reset removes the write immediately.
  assign req_ready  = (state_reg == S_IDLE);
  assign rsp_valid  = (state_reg == S_RESP);
  assign d_wr_en    = (state_reg == S_ACCESS) && we_reg;
  assign rsp_rdata  = rdata_reg;
  assign rsp_err    = err_reg;
  assign dAddr      = addr_reg;
  assign dWdata     = wdata_reg;
  assign store_size = size_reg;
  assign load_size  = size_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl with a byte-addressable memory model,
// a table of request vectors and a scoreboard queue of expected responses.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        d_wr_en;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [1:0]  store_size;
  logic [1:0]  load_size;
  logic [31:0] dRdata;

  lsu_mem_ctrl #(
    .MEM_BYTES(128),
    .XLEN(32)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .d_wr_en(d_wr_en), .dAddr(dAddr), .dWdata(dWdata),
    .store_size(store_size), .load_size(load_size), .dRdata(dRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: little-endian bytes, synchronous write, combinational sign-extended read.
  logic [7:0] mem [0:127];
  logic       mem_init;
  int         wr_cnt;
  logic [6:0] a0, a1, a2, a3;

  assign a0 = dAddr[6:0];
  assign a1 = a0 + 7'd1;
  assign a2 = a0 + 7'd2;
  assign a3 = a0 + 7'd3;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      mem[7'h40] <= 8'h21; mem[7'h41] <= 8'h43; mem[7'h42] <= 8'h65; mem[7'h43] <= 8'h87;
      mem[7'h7C] <= 8'h44; mem[7'h7D] <= 8'h33; mem[7'h7E] <= 8'h22; mem[7'h7F] <= 8'h11;
    end else if (d_wr_en) begin
      mem[a0] <= dWdata[7:0];
      if (store_size != SIZE_B) mem[a1] <= dWdata[15:8];
      if (store_size == SIZE_W) begin
        mem[a2] <= dWdata[23:16];
        mem[a3] <= dWdata[31:24];
      end
    end
  end

  always @(posedge clk) begin
    if (d_wr_en) wr_cnt <= wr_cnt + 1;
  end

  always_comb begin
    case (load_size)
      SIZE_B:  dRdata = {{24{mem[a0][7]}}, mem[a0]};
      SIZE_H:  dRdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      default: dRdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
    endcase
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction; hold>0 keeps rsp_ready low for that many cycles of the response.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] erd,
                         input logic [1:0] eerr, input int hold);
    exp_t e;
    exp_t got;
    int   waited;
    int   wr0;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    waited = 0;
    while (!req_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    e.rdata = erd; e.err = eerr; e.lat = (eerr == ERR_OK) ? 1 : 0;
    sb.push_back(e);
    wr0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (!rsp_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    got = sb.pop_front();
    if (!rsp_valid) begin
      check("rsp_timeout", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      return;
    end
    check("latency", 64'(waited), 64'(got.lat));
    for (int k = 0; k < hold; k++) begin
      check("hold_stable", {28'd0, rsp_valid, req_ready, rsp_rdata, rsp_err},
            {28'd0, 1'b1, 1'b0, got.rdata, got.err});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("rdata", 64'(rsp_rdata), 64'(got.rdata));
    check("err", 64'(rsp_err), 64'(got.err));
    $display("[TB] txn we=%0d f3=%0d addr=0x%08h rdata=0x%08h err=%0d", we, f3, addr, rsp_rdata, rsp_err);
    @(negedge clk);
    check("rsp_drop", {62'd0, rsp_valid, req_ready}, 64'b01);
    check("wr_pulses", 64'(wr_cnt - wr0), (we && eerr == ERR_OK) ? 64'd1 : 64'd0);
  endtask

  vec_t vecs[22];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    tests = 0; fails = 0; wr_cnt = 0;
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;

    //        we    f3      addr          wdata         rdata         err
    vecs[0]  = '{1'b1, F3_SW,  32'h10,       32'hDEADBEEF, 32'h0,        ERR_OK};
    vecs[1]  = '{1'b0, F3_LW,  32'h10,       32'h0,        32'hDEADBEEF, ERR_OK};
    vecs[2]  = '{1'b1, F3_SB,  32'h21,       32'h80,       32'h0,        ERR_OK};
    vecs[3]  = '{1'b0, F3_LB,  32'h21,       32'h0,        32'hFFFFFF80, ERR_OK};
    vecs[4]  = '{1'b0, F3_LBU, 32'h21,       32'h0,        32'h00000080, ERR_OK};
    vecs[5]  = '{1'b0, F3_LH,  32'h03,       32'h0,        32'h0,        ERR_MISAL};
    vecs[6]  = '{1'b0, F3_LW,  32'h7E,       32'h0,        32'h0,        ERR_MISAL};
    vecs[7]  = '{1'b1, F3_SW,  32'h06,       32'h55555555, 32'h0,        ERR_MISAL};
    vecs[8]  = '{1'b0, F3_LW,  32'h7C,       32'h0,        32'h11223344, ERR_OK};
    vecs[9]  = '{1'b0, F3_LW,  32'h80,       32'h0,        32'h0,        ERR_OOR};
    vecs[10] = '{1'b1, F3_SH,  32'h7F,       32'h1234,     32'h0,        ERR_MISAL};
    vecs[11] = '{1'b1, F3_SB,  32'hFFFFFFFF, 32'h77,       32'h0,        ERR_OOR};
    vecs[12] = '{1'b0, 3'b011, 32'h40,       32'h0,        32'h0,        ERR_ILL};
    vecs[13] = '{1'b1, 3'b100, 32'h40,       32'hAAAAAAAA, 32'h0,        ERR_ILL};
    vecs[14] = '{1'b0, F3_LW,  32'h40,       32'h0,        32'h87654321, ERR_OK};
    vecs[15] = '{1'b1, F3_SH,  32'h42,       32'h0000BEEF, 32'h0,        ERR_OK};
    vecs[16] = '{1'b0, F3_LHU, 32'h42,       32'h0,        32'h0000BEEF, ERR_OK};
    vecs[17] = '{1'b0, F3_LH,  32'h42,       32'h0,        32'hFFFFBEEF, ERR_OK};
    vecs[18] = '{1'b0, F3_LW,  32'h40,       32'h0,        32'hBEEF4321, ERR_OK};
    vecs[19] = '{1'b1, F3_SB,  32'h7F,       32'h5A,       32'h0,        ERR_OK};
    vecs[20] = '{1'b0, F3_LBU, 32'h7F,       32'h0,        32'h0000005A, ERR_OK};
    vecs[21] = '{1'b0, F3_LH,  32'h7E,       32'h0,        32'h00005A22, ERR_OK};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(req_ready), 64'd1);
    check("reset_outputs", {rsp_valid, rsp_rdata, rsp_err, d_wr_en, store_size, load_size},
          {1'b0, 32'h0, 2'b00, 1'b0, SIZE_W, SIZE_W});
    check("reset_daddr", {dAddr, dWdata}, 64'd0);
    reset = 1'b0; mem_init = 1'b0;

    for (int i = 0; i < 22; i++) begin
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
              vecs[i].rdata, vecs[i].err, 0);
    end

    // Back-pressure: response must stay put while rsp_ready is low.
    run_req(1'b0, F3_LW, 32'h10, 32'h0, 32'hDEADBEEF, ERR_OK, 5);
    run_req(1'b0, F3_LW, 32'h81, 32'h0, 32'h0, ERR_MISAL, 5);

    // Reset during ACCESS of a store: strobe drops immediately and no write lands.
    wr0 = wr_cnt;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h10; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("access_wr_en", 64'(d_wr_en), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_wr_en", 64'(d_wr_en), 64'd0);
    check("abort_state", {61'd0, req_ready, rsp_valid, d_wr_en}, 64'b100);
    check("abort_regs", {dAddr, 30'd0, store_size}, {32'h0, 30'd0, SIZE_W});
    @(negedge clk);
    reset = 1'b0;
    check("abort_no_write", 64'(wr_cnt - wr0), 64'd0);
    $display("[TB] txn reset-abort SW addr=0x00000010");
    run_req(1'b0, F3_LW, 32'h10, 32'h0, 32'hDEADBEEF, ERR_OK, 0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
